// File: rtl/register_file_mp_pkg.sv
// Shared defaults and helpers for the multi-port register file.
// Replaces the old riscv_defs.vh include.
package register_file_mp_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an address names a real, writable register.
    function automatic logic addr_valid(
        input logic [31:0] a,
        input logic [31:0] cnt,
        input logic        zero
    );
        return (a < cnt) && !(zero && (a == 32'(REG_ZERO)));
    endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Decode/writeback side bundle of the register file.
// Master drives reads, writes and reservations.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1
);
    logic [NUM_WR-1:0]            WE;
    logic [NUM_WR*ADDR_WIDTH-1:0] WA;
    logic [NUM_WR*DATA_WIDTH-1:0] WD;
    logic [NUM_RD*ADDR_WIDTH-1:0] RA;
    logic [NUM_RD*DATA_WIDTH-1:0] RD;
    logic                         RSV_EN;
    logic [ADDR_WIDTH-1:0]        RSV_A;
    logic [NUM_RD-1:0]            BUSY;

    modport master (
        output WE, WA, WD, RA, RSV_EN, RSV_A,
        input  RD, BUSY
    );

    modport slave (
        input  WE, WA, WD, RA, RSV_EN, RSV_A,
        output RD, BUSY
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Pending-write busy bits, one per register.
// A reservation beats a same-cycle write to the same register.
module reg_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int REG_COUNT  = NUM_REGS,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_WR-1:0]            wr_ok_i,
    input  logic [NUM_WR*ADDR_WIDTH-1:0] wa_i,
    input  logic                         rsv_en_i,
    input  logic [ADDR_WIDTH-1:0]        rsv_a_i,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] ra_i,
    input  logic [NUM_RD-1:0]            byp_i,
    output logic [NUM_RD-1:0]            busy_o
);
    logic [REG_COUNT-1:0] busy_q;
    logic [REG_COUNT-1:0] busy_d;
    logic                 rsv_ok;

    assign rsv_ok = rsv_en_i && addr_valid(
        32'(rsv_a_i), 32'(REG_COUNT), ZERO_REG != 0);

    // Writes retire pending bits, then reservations set them.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < REG_COUNT; r++) begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_ok_i[k] &&
                    wa_i[k*ADDR_WIDTH +: ADDR_WIDTH] == ADDR_WIDTH'(r))
                    busy_d[r] = 1'b0;
            end
            if (rsv_ok && rsv_a_i == ADDR_WIDTH'(r))
                busy_d[r] = 1'b1;
        end
    end

    // Busy array update; reset drops every reservation.
    always_ff @(posedge clk_i) begin
        if (rst_i) busy_q <= '0;
        else       busy_q <= busy_d;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_look
        logic [ADDR_WIDTH-1:0] ra;
        logic                  hit;
        assign ra = ra_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Per-port lookup, masked when the value is being forwarded.
        always_comb begin
            hit = 1'b0;
            for (int r = 0; r < REG_COUNT; r++)
                if (ra == ADDR_WIDTH'(r)) hit = busy_q[r];
        end
        assign busy_o[i] = hit && !byp_i[i];
    end
endmodule

// File: rtl/register_file_mp.sv
// Multi-port integer register file with write bypass
// and pending-write scoreboard.
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int DATA_WIDTH = XLEN,
    parameter int ADDR_WIDTH = REG_ADDR_W,
    parameter int REG_COUNT  = NUM_REGS,
    parameter int NUM_RD     = 2,
    parameter int NUM_WR     = 1,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic               CLK,
    input  logic               RST,
    register_file_mp_if.slave  bus
);
    logic [DATA_WIDTH-1:0] regs_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] regs_d [REG_COUNT];
    logic [ADDR_WIDTH-1:0] wa     [NUM_WR];
    logic [DATA_WIDTH-1:0] wd     [NUM_WR];
    logic [NUM_WR-1:0]     wr_ok;
    logic [NUM_RD-1:0]     byp;

    for (genvar k = 0; k < NUM_WR; k++) begin : g_wr
        assign wa[k] = bus.WA[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign wd[k] = bus.WD[k*DATA_WIDTH +: DATA_WIDTH];
        assign wr_ok[k] = bus.WE[k] && addr_valid(
            32'(wa[k]), 32'(REG_COUNT), ZERO_REG != 0);
    end

    // Write merge; later ports override earlier ones.
    always_comb begin
        regs_d = regs_q;
        for (int r = 0; r < REG_COUNT; r++)
            for (int k = 0; k < NUM_WR; k++)
                if (wr_ok[k] && wa[k] == ADDR_WIDTH'(r))
                    regs_d[r] = wd[k];
    end

    // Storage update; no write completes in a reset cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int r = 0; r < REG_COUNT; r++) regs_q[r] <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_WIDTH-1:0] ra;
        logic [DATA_WIDTH-1:0] rd;
        logic                  hit;
        assign ra = bus.RA[i*ADDR_WIDTH +: ADDR_WIDTH];
        // Read mux with optional forwarding, highest port wins.
        always_comb begin
            rd  = '0;
            hit = 1'b0;
            if (addr_valid(32'(ra), 32'(REG_COUNT), ZERO_REG != 0)) begin
                for (int r = 0; r < REG_COUNT; r++)
                    if (ra == ADDR_WIDTH'(r)) rd = regs_q[r];
                for (int k = 0; k < NUM_WR; k++) begin
                    if (BYPASS != 0 && wr_ok[k] && wa[k] == ra) begin
                        rd  = wd[k];
                        hit = 1'b1;
                    end
                end
            end
        end
        assign bus.RD[i*DATA_WIDTH +: DATA_WIDTH] = rd;
        assign byp[i] = hit;
    end

    reg_scoreboard #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .NUM_RD     (NUM_RD),
        .NUM_WR     (NUM_WR),
        .ZERO_REG   (ZERO_REG)
    ) u_sb (
        .clk_i    (CLK),
        .rst_i    (RST),
        .wr_ok_i  (wr_ok),
        .wa_i     (bus.WA),
        .rsv_en_i (bus.RSV_EN),
        .rsv_a_i  (bus.RSV_A),
        .ra_i     (bus.RA),
        .byp_i    (byp),
        .busy_o   (bus.BUSY)
    );
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: two DUTs (bypass on / off) share
// one stimulus stream, 2 read and 2 write ports.
module tb_register_file_mp;
    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [9:0]  wa;
    logic [63:0] wd;
    logic [9:0]  ra;
    logic        rsv_en;
    logic [4:0]  rsv_a;
    int          vectors = 0;
    int          errs = 0;

    register_file_mp_if #(.NUM_RD(2), .NUM_WR(2)) if_a ();
    register_file_mp_if #(.NUM_RD(2), .NUM_WR(2)) if_b ();

    assign if_a.WE = we;     assign if_b.WE = we;
    assign if_a.WA = wa;     assign if_b.WA = wa;
    assign if_a.WD = wd;     assign if_b.WD = wd;
    assign if_a.RA = ra;     assign if_b.RA = ra;
    assign if_a.RSV_EN = rsv_en;
    assign if_b.RSV_EN = rsv_en;
    assign if_a.RSV_A = rsv_a;
    assign if_b.RSV_A = rsv_a;

    register_file_mp #(
        .NUM_RD(2), .NUM_WR(2), .BYPASS(1), .ZERO_REG(1)
    ) u_a (.CLK(clk), .RST(rst), .bus(if_a));

    register_file_mp #(
        .NUM_RD(2), .NUM_WR(2), .BYPASS(0), .ZERO_REG(1)
    ) u_b (.CLK(clk), .RST(rst), .bus(if_b));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic wr(input int p, input logic [4:0] a,
                      input logic [31:0] d);
        we[p] = 1'b1;
        wa[p*5 +: 5] = a;
        wd[p*32 +: 32] = d;
    endtask

    initial begin
        rst = 1'b1; we = '0; wa = '0; wd = '0;
        ra = '0; rsv_en = 1'b0; rsv_a = '0;
        step();
        rst = 1'b0;
        // 1: random traffic, then reset with writes pending
        for (int n = 0; n < 6; n++) begin
            we = 2'b11;
            wa = 10'($urandom);
            wd = {$urandom, $urandom};
            rsv_en = 1'b1;
            rsv_a = 5'($urandom_range(1, 31));
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0; we = '0; rsv_en = 1'b0;
        for (int a = 0; a < 32; a++) begin
            ra = {5'(a), 5'(a)};
            #1;
            chk("rst_rd0", if_a.RD[31:0], 32'd0);
            chk("rst_rd1", if_b.RD[63:32], 32'd0);
            chk("rst_busy", {30'd0, if_a.BUSY}, 32'd0);
        end
        // 2: fill and readback
        for (int i = 1; i < 32; i++) begin
            we = '0;
            wr(0, 5'(i), 32'(i + 10));
            step();
        end
        we = '0;
        for (int i = 1; i < 32; i++) begin
            ra = {5'(32 - i), 5'(i)};
            #1;
            chk("fill_rd0", if_a.RD[31:0], 32'(i + 10));
            chk("fill_rd1", if_b.RD[63:32], 32'(42 - i));
        end
        ra = '0;
        wr(0, 5'd0, 32'hDEAD);
        #1;
        chk("x0_pre", if_a.RD[31:0], 32'd0);
        step();
        we = '0;
        #1;
        chk("x0_post_a", if_a.RD[31:0], 32'd0);
        chk("x0_post_b", if_b.RD[31:0], 32'd0);
        // 3: write conflict, port 1 wins
        wr(0, 5'd5, 32'd1);
        wr(1, 5'd5, 32'd2);
        ra = {5'd0, 5'd5};
        #1;
        chk("conf_byp_a", if_a.RD[31:0], 32'd2);
        chk("conf_nobyp_b", if_b.RD[31:0], 32'd15);
        step();
        we = '0;
        #1;
        chk("conf_post_a", if_a.RD[31:0], 32'd2);
        chk("conf_post_b", if_b.RD[31:0], 32'd2);
        // 4: bypass on vs off
        wr(0, 5'd7, 32'd3);
        step();
        we = '0;
        wr(0, 5'd7, 32'd9);
        ra = {5'd7, 5'd0};
        #1;
        chk("byp_pre_a", if_a.RD[63:32], 32'd9);
        chk("byp_pre_b", if_b.RD[63:32], 32'd3);
        step();
        we = '0;
        #1;
        chk("byp_post_a", if_a.RD[63:32], 32'd9);
        chk("byp_post_b", if_b.RD[63:32], 32'd9);
        // 5: scoreboard
        rsv_en = 1'b1; rsv_a = 5'd12;
        step();
        rsv_en = 1'b0;
        ra = {5'd0, 5'd12};
        #1;
        chk("rsv_a", {31'd0, if_a.BUSY[0]}, 32'd1);
        chk("rsv_b", {31'd0, if_b.BUSY[0]}, 32'd1);
        wr(0, 5'd12, 32'd55);
        #1;
        chk("mask_a", {31'd0, if_a.BUSY[0]}, 32'd0);
        chk("mask_b", {31'd0, if_b.BUSY[0]}, 32'd1);
        step();
        we = '0;
        #1;
        chk("clr_a", {31'd0, if_a.BUSY[0]}, 32'd0);
        chk("clr_b", {31'd0, if_b.BUSY[0]}, 32'd0);
        chk("clr_rd", if_b.RD[31:0], 32'd55);
        rsv_en = 1'b1; rsv_a = 5'd12;
        wr(0, 5'd12, 32'd66);
        step();
        rsv_en = 1'b0; we = '0;
        #1;
        chk("rw_busy_a", {31'd0, if_a.BUSY[0]}, 32'd1);
        chk("rw_busy_b", {31'd0, if_b.BUSY[0]}, 32'd1);
        chk("rw_rd", if_a.RD[31:0], 32'd66);
        rsv_en = 1'b1; rsv_a = 5'd0;
        step();
        rsv_en = 1'b0;
        ra = {5'd0, 5'd12};
        #1;
        chk("rsv0_busy", {31'd0, if_a.BUSY[1]}, 32'd0);
        // 6: reset mid-flight
        rsv_en = 1'b1; rsv_a = 5'd4;
        step();
        rsv_a = 5'd6;
        step();
        rsv_en = 1'b0;
        ra = {5'd6, 5'd4};
        #1;
        chk("mid_busy4", {31'd0, if_b.BUSY[0]}, 32'd1);
        chk("mid_busy6", {31'd0, if_b.BUSY[1]}, 32'd1);
        rst = 1'b1;
        wr(0, 5'd4, 32'd77);
        step();
        rst = 1'b0; we = '0;
        #1;
        chk("mid_rd4_a", if_a.RD[31:0], 32'd0);
        chk("mid_rd4_b", if_b.RD[31:0], 32'd0);
        chk("mid_busy_a", {30'd0, if_a.BUSY}, 32'd0);
        chk("mid_busy_b", {30'd0, if_b.BUSY}, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errs);
        $finish;
    end
endmodule
